// File: rtl/uart_frame_rx.sv
// Frames the UART byte stream (SYNC, LEN, payload, CHK) into a held, checksummed buffer; read port has 1-cycle latency.
// No backpressure to the UART: bytes arriving while a frame is held are dropped and flagged with an overrun pulse.
module uart_frame_rx #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 12000,
    localparam int        LW           = $clog2(MAX_LEN + 1),
    localparam int        AW           = $clog2(MAX_LEN),
    localparam int        TW           = $clog2(TIMEOUT_CLKS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_byte,
    input  logic          byte_available,
    output logic          frame_valid,
    output logic [LW-1:0] frame_len,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    input  logic          frame_ack,
    output logic          chk_error,
    output logic          len_error,
    output logic          timeout,
    output logic          overrun
);

    typedef enum logic [2:0] {S_SYNC, S_LEN, S_PAYLOAD, S_CHECK, S_HOLD} state_t;

    state_t          state_q;
    logic            bav_q;
    logic [LW-1:0]   len_q, idx_q, frame_len_q;
    logic [7:0]      sum_q, rd_data_q;
    logic [TW-1:0]   tcnt_q;
    logic            frame_valid_q, chk_error_q, len_error_q, timeout_q, overrun_q;
    logic [7:0]      pl_mem_q [MAX_LEN];
    logic            strobe, tmo_hit;

    assign strobe  = byte_available & ~bav_q;
    assign tmo_hit = (tcnt_q == TW'(TIMEOUT_CLKS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_SYNC;
            bav_q         <= 1'b0;
            len_q         <= '0;
            idx_q         <= '0;
            sum_q         <= '0;
            tcnt_q        <= '0;
            frame_valid_q <= 1'b0;
            frame_len_q   <= '0;
            chk_error_q   <= 1'b0;
            len_error_q   <= 1'b0;
            timeout_q     <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            bav_q       <= byte_available;
            chk_error_q <= 1'b0;
            len_error_q <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
            if (state_q == S_LEN || state_q == S_PAYLOAD || state_q == S_CHECK)
                tcnt_q <= strobe ? '0 : tcnt_q + TW'(1);
            else
                tcnt_q <= '0;

            // A strobe on the terminal-count cycle wins over the timeout.
            case (state_q)
                S_SYNC: begin
                    if (strobe && rx_byte == SYNC_BYTE)
                        state_q <= S_LEN;
                end
                S_LEN: begin
                    if (strobe) begin
                        len_q <= LW'(rx_byte);
                        sum_q <= rx_byte;
                        idx_q <= '0;
                        if (int'(rx_byte) > MAX_LEN) begin
                            len_error_q <= 1'b1;
                            state_q     <= S_SYNC;
                        end else if (rx_byte == 8'd0) begin
                            state_q <= S_CHECK;
                        end else begin
                            state_q <= S_PAYLOAD;
                        end
                    end else if (tmo_hit) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_SYNC;
                    end
                end
                S_PAYLOAD: begin
                    if (strobe) begin
                        sum_q <= sum_q + rx_byte;
                        idx_q <= idx_q + LW'(1);
                        if (idx_q + LW'(1) == len_q)
                            state_q <= S_CHECK;
                    end else if (tmo_hit) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_SYNC;
                    end
                end
                S_CHECK: begin
                    if (strobe) begin
                        if (rx_byte == sum_q) begin
                            frame_valid_q <= 1'b1;
                            frame_len_q   <= len_q;
                            state_q       <= S_HOLD;
                        end else begin
                            chk_error_q <= 1'b1;
                            state_q     <= S_SYNC;
                        end
                    end else if (tmo_hit) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_SYNC;
                    end
                end
                S_HOLD: begin
                    if (strobe)
                        overrun_q <= 1'b1;
                    if (frame_ack) begin
                        frame_valid_q <= 1'b0;
                        state_q       <= S_SYNC;
                    end
                end
                default: state_q <= S_SYNC;
            endcase
        end
    end

    // Buffer is written only while collecting payload, so it stays frozen in S_HOLD.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_PAYLOAD && strobe)
            pl_mem_q[idx_q[AW-1:0]] <= rx_byte;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rd_data_q <= '0;
        else
            rd_data_q <= pl_mem_q[rd_addr];
    end

    assign frame_valid = frame_valid_q;
    assign frame_len   = frame_len_q;
    assign rd_data     = rd_data_q;
    assign chk_error   = chk_error_q;
    assign len_error   = len_error_q;
    assign timeout     = timeout_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Scoreboard bench for uart_frame_rx: expected frames/error pulses are queued as bytes are driven.
module tb_uart_frame_rx;

    localparam int K_FRAME = 0, K_CHK = 1, K_LEN = 2, K_TMO = 3, K_OVR = 4, K_NONE = 15;

    typedef struct {
        int kind;
        int len;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_byte;
    logic       byte_available;
    logic       frame_valid;
    logic [4:0] frame_len;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_ack;
    logic       chk_error, len_error, timeout, overrun;

    int         n_vec = 0;
    int         n_err = 0;
    ev_t        exp_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] exp_pl[$];
    logic       fv_prev;

    uart_frame_rx dut (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .byte_available(byte_available),
        .frame_valid(frame_valid), .frame_len(frame_len), .rd_addr(rd_addr),
        .rd_data(rd_data), .frame_ack(frame_ack), .chk_error(chk_error),
        .len_error(len_error), .timeout(timeout), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_ev(input int kind, input int len);
        ev_t e;
        e.kind = kind;
        e.len  = len;
        exp_q.push_back(e);
    endtask

    task automatic handle_event(input int kind, input int len);
        ev_t e;
        if (exp_q.size() == 0) begin
            check_eq("unexpected_evt", kind, K_NONE);
        end else begin
            e = exp_q.pop_front();
            check_eq("evt_kind", kind, e.kind);
            if (kind == K_FRAME && e.kind == K_FRAME)
                check_eq("frame_len", len, e.len);
        end
    endtask

    // Monitor: every pulse and every rising frame_valid must match the head of the scoreboard.
    initial begin
        fv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                int n;
                int kind;
                n = int'(chk_error) + int'(len_error) + int'(timeout) + int'(overrun);
                kind = chk_error ? K_CHK : len_error ? K_LEN : timeout ? K_TMO : K_OVR;
                if (n > 1) check_eq("pulse_onehot", n, 1);
                if (n > 0) handle_event(kind, 0);
                if (frame_valid && !fv_prev) handle_event(K_FRAME, int'(frame_len));
            end
            fv_prev = frame_valid;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int hold);
        rx_byte        = b;
        byte_available = 1'b1;
        repeat (hold) @(negedge clk);
        byte_available = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_tx(input int hold);
        while (tx_q.size() != 0) send_byte(tx_q.pop_front(), hold);
    endtask

    task automatic send_frame(input int hold);
        logic [7:0] s;
        s = 8'(exp_pl.size());
        tx_q.push_back(8'hA5);
        tx_q.push_back(s);
        foreach (exp_pl[i]) begin
            tx_q.push_back(exp_pl[i]);
            s = s + exp_pl[i];
        end
        tx_q.push_back(s);
        push_ev(K_FRAME, exp_pl.size());
        send_tx(hold);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        check_eq(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic read_back(input string tag);
        check_eq({tag, "_fv"}, frame_valid, 1'b1);
        foreach (exp_pl[i]) begin
            rd_addr = 4'(i);
            @(negedge clk);
            check_eq(tag, rd_data, exp_pl[i]);
        end
    endtask

    task automatic ack_frame();
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        check_eq("ack_fv", frame_valid, 1'b0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_fv"},  frame_valid, 1'b0);
        check_eq({tag, "_len"}, frame_len, 5'd0);
        check_eq({tag, "_rd"},  rd_data, 8'd0);
        check_eq({tag, "_pulses"}, {chk_error, len_error, timeout, overrun}, 4'd0);
    endtask

    task automatic rand_payload(input int len);
        exp_pl.delete();
        for (int i = 0; i < len; i++) exp_pl.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        rst = 1'b1; rx_byte = '0; byte_available = 1'b0; rd_addr = '0; frame_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Literal good frame.
        tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        exp_pl = '{8'h11, 8'h22, 8'h33};
        push_ev(K_FRAME, 3);
        send_tx(3);
        wait_drain("drain_good", 50);
        read_back("good_rd");
        ack_frame();

        // Bad checksum, then a literal good frame.
        push_ev(K_CHK, 0);
        tx_q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
        send_tx(3);
        wait_drain("drain_chk", 50);
        check_eq("chk_fv", frame_valid, 1'b0);
        tx_q = '{8'hA5, 8'h01, 8'h07, 8'h08};
        exp_pl = '{8'h07};
        push_ev(K_FRAME, 1);
        send_tx(3);
        wait_drain("drain_after_chk", 50);
        read_back("after_chk_rd");
        ack_frame();

        // Length boundaries: 0, MAX_LEN, MAX_LEN+1.
        exp_pl.delete();
        send_frame(2);
        wait_drain("drain_len0", 50);
        check_eq("len0_fv", frame_valid, 1'b1);
        ack_frame();
        exp_pl.delete();
        for (int i = 0; i < 16; i++) exp_pl.push_back(8'h01);
        send_frame(2);
        wait_drain("drain_len16", 50);
        read_back("len16_rd");
        ack_frame();
        push_ev(K_LEN, 0);
        tx_q = '{8'hA5, 8'h11};
        send_tx(2);
        wait_drain("drain_lenerr", 50);

        // Junk before SYNC, long byte_available level.
        tx_q = '{8'h00, 8'hFF, 8'h5A};
        exp_pl = '{8'h11, 8'h22, 8'h33};
        send_frame(20);
        wait_drain("drain_junk", 50);
        read_back("junk_rd");
        ack_frame();

        // Inter-byte timeout, then a random frame.
        push_ev(K_TMO, 0);
        tx_q = '{8'hA5, 8'h02, 8'hAA};
        send_tx(2);
        wait_drain("drain_tmo", 13000);
        rand_payload(5);
        send_frame(2);
        wait_drain("drain_after_tmo", 50);
        read_back("after_tmo_rd");
        ack_frame();

        // Reset mid-payload.
        tx_q = '{8'hA5, 8'h04, 8'h01, 8'h02};
        send_tx(2);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("midrst");
        rst = 1'b0;
        @(negedge clk);
        rand_payload(7);
        send_frame(2);
        wait_drain("drain_after_rst", 50);
        read_back("after_rst_rd");
        ack_frame();

        // Overrun while held, then a strobe coincident with frame_ack.
        exp_pl = '{8'h11, 8'h22, 8'h33};
        send_frame(2);
        wait_drain("drain_hold", 50);
        push_ev(K_OVR, 0);
        send_byte(8'h5A, 2);
        wait_drain("drain_ovr", 50);
        read_back("ovr_rd");
        push_ev(K_OVR, 0);
        rx_byte = 8'hA5; byte_available = 1'b1; frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        check_eq("ovr_ack_fv", frame_valid, 1'b0);
        repeat (3) @(negedge clk);
        byte_available = 1'b0;
        repeat (2) @(negedge clk);
        wait_drain("drain_ovr_ack", 50);
        rand_payload(2);
        send_frame(2);
        wait_drain("drain_final", 50);
        read_back("final_rd");
        ack_frame();

        repeat (5) @(negedge clk);
        check_eq("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
